md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//  Multiply/divide unit and its sequencer for the 5-stage pipeline, sitting in the E stage beside the ALU.
//  Accepts one mult/multu/div/divu/mthi/mtlo per start pulse and models a multi-cycle latency with a busy counter.
//  Owns the HI/LO registers and raises a stall request to the hazard unit while a D-stage instruction needs the unit.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   pipeline clock, rising edge
//  reset     in   1   asynchronous, active-low; 0 clears all state immediately
//  start     in   1   E-stage instr is an MD op; sampled at rising edge
//  mdop      in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others reserved
//  srcA      in   32  rs operand (already forwarded)
//  srcB      in   32  rt operand (already forwarded)
//  use_md_D  in   1   D-stage instr is mult/div/mfhi/mflo/mthi/mtlo
//  busy      out  1   operation in progress
//  hi        out  32  HI register
//  lo        out  32  LO register
//  stall_md  out  1   stall request to hazard unit (combinational)
// BEHAVIOUR
//  Reset values: busy=0, hi=0, lo=0, counter=0, state=IDLE; stall_md=0 while reset=0.
//  States: IDLE, RUN. Internal: cnt (width ceil(log2(max(MULT,DIV)+1))), res_hi/res_lo (32 each).
//  IDLE, start=1, mdop mult/multu: compute 64-bit product now, latch into res_hi/res_lo; cnt<=MULT_CYCLES; ->RUN.
//  IDLE, start=1, mdop div/divu: latch quotient->res_lo, remainder->res_hi; cnt<=DIV_CYCLES; ->RUN.
//  IDLE, start=1, mthi/mtlo: hi<=srcA / lo<=srcA at that edge; no busy, stay IDLE.
//  IDLE, start=1, reserved mdop: ignored, no state change.
//  RUN: cnt decrements each edge; busy=1 in RUN. At edge where cnt==1: hi<=res_hi, lo<=res_lo, cnt<=0, ->IDLE.
//  Latency: start sampled at edge t -> busy high for cycles t..t+N-1 (N = MULT/DIV_CYCLES), hi/lo updated and busy
//   low at edge t+N. mfhi/mflo in D never sees stale values because stall_md covers the whole window.
//  start while RUN: ignored (hazard unit must prevent it); includes mthi/mtlo, hi/lo untouched.
//  Signed mult: $signed 32x32->64; multu: unsigned 64.
//  div: quotient truncates toward zero; remainder takes sign of dividend (srcA).
//  div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//  Division by zero (div or divu): full DIV_CYCLES busy window still occurs; hi/lo keep prior values at completion.
//  stall_md = use_md_D & (busy | (start & mdop is mult/multu/div/divu)).
//  mthi/mtlo in E with mfhi/mflo in D: no stall; hi/lo written at next edge, before the D instr reaches E.
//  reset asserted mid-RUN: immediately IDLE, busy=0, hi=lo=0, pending result discarded.
//  The hazard unit freezes PC and IF/ID and clears ID/EX when stall_md=1; this block does not hold start itself.
// TESTING
//  mult srcA=3, srcB=0xFFFFFFFE -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA, busy=0.
//  multu srcA=0xFFFFFFFF, srcB=2 -> after 5 cycles hi=0x00000001 lo=0xFFFFFFFE.
//  div srcA=0xFFFFFFF9 (-7), srcB=2 -> after 10 cycles lo=0xFFFFFFFD hi=0xFFFFFFFF; div 0x80000000/-1 -> lo=0x80000000 hi=0.
//  divu srcB=0 with hi=0x11,lo=0x22 preloaded via mthi/mtlo -> busy 10 cycles, hi=0x11 lo=0x22 unchanged.
//  use_md_D=1 on start edge and throughout busy -> stall_md=1 each cycle, 0 the cycle busy drops; use_md_D=0 -> stall_md=0.
//  mult started, reset=0 at cycle 2 -> busy=0, hi=lo=0 at once; second start during RUN -> ignored, first result lands.

Source files
------------

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_if
// Description : Bundles the E-stage request, D-stage usage hint and the
//               multiply/divide results for the md_unit.
// Revision    : 1.0  initial release
// ============================================================================
interface md_unit_if;
   logic        start;
   logic [2:0]  mdop;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        use_md_D;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        stall_md;

   // Pipeline side driving the unit
   modport master (
      output start, mdop, srcA, srcB, use_md_D,
      input  busy, hi, lo, stall_md
   );

   // The multiply/divide unit itself
   modport slave (
      input  start, mdop, srcA, srcB, use_md_D,
      output busy, hi, lo, stall_md
   );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Multiply/divide unit with HI/LO registers. The result is
//               computed at the start edge and held back for a fixed busy
//               window so that software sees a multi-cycle latency.
// Revision    : 1.0  initial release
// ============================================================================
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  wire logic clk,
   input  wire logic reset,
   md_unit_if.slave  bus
);

   localparam int c_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_CW   = $clog2(c_MAXC + 1);

   localparam logic [c_CW-1:0] c_MULT_CNT = c_CW'(MULT_CYCLES);
   localparam logic [c_CW-1:0] c_DIV_CNT  = c_CW'(DIV_CYCLES);
   localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

   localparam logic [2:0] c_OP_MULT  = 3'b000;
   localparam logic [2:0] c_OP_MULTU = 3'b001;
   localparam logic [2:0] c_OP_DIV   = 3'b010;
   localparam logic [2:0] c_OP_DIVU  = 3'b011;
   localparam logic [2:0] c_OP_MTHI  = 3'b100;
   localparam logic [2:0] c_OP_MTLO  = 3'b101;

   localparam logic [0:0] c_S_IDLE = 1'b0;
   localparam logic [0:0] c_S_RUN  = 1'b1;

   logic [0:0]      r_state;
   logic [0:0]      w_state_nxt;
   logic [c_CW-1:0] r_cnt;
   logic [31:0]     r_res_hi;
   logic [31:0]     r_res_lo;
   logic            r_res_vld;
   logic [31:0]     r_hi;
   logic [31:0]     r_lo;
   logic            w_busy;

   logic            w_is_long;
   logic [63:0]     w_prod_s;
   logic [63:0]     w_prod_u;
   logic            w_sdiv;
   logic [31:0]     w_a_mag;
   logic [31:0]     w_b_mag;
   logic [31:0]     w_q_mag;
   logic [31:0]     w_r_mag;
   logic [31:0]     w_quot;
   logic [31:0]     w_rem;
   logic            w_div_zero;

   // Only mult/multu/div/divu occupy the unit for a busy window
   assign w_is_long = (bus.mdop == c_OP_MULT) || (bus.mdop == c_OP_MULTU) ||
                      (bus.mdop == c_OP_DIV)  || (bus.mdop == c_OP_DIVU);

   // Sign-extended operands give the signed product in the low 64 bits
   assign w_prod_s = {{32{bus.srcA[31]}}, bus.srcA} * {{32{bus.srcB[31]}}, bus.srcB};
   assign w_prod_u = {32'd0, bus.srcA} * {32'd0, bus.srcB};

   // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly
   assign w_sdiv     = (bus.mdop == c_OP_DIV);
   assign w_div_zero = (bus.srcB == 32'd0);
   assign w_a_mag    = (w_sdiv && bus.srcA[31]) ? (32'd0 - bus.srcA) : bus.srcA;
   assign w_b_mag    = w_div_zero ? 32'd1 :
                       ((w_sdiv && bus.srcB[31]) ? (32'd0 - bus.srcB) : bus.srcB);
   assign w_q_mag    = w_a_mag / w_b_mag;
   assign w_r_mag    = w_a_mag % w_b_mag;
   assign w_quot     = (w_sdiv && (bus.srcA[31] ^ bus.srcB[31])) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem      = (w_sdiv && bus.srcA[31]) ? (32'd0 - w_r_mag) : w_r_mag;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: enter RUN on a long op, leave on the last count
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE: if (bus.start && w_is_long) w_state_nxt = c_S_RUN;
         c_S_RUN:  if (r_cnt == c_CNT_ONE)     w_state_nxt = c_S_IDLE;
         default:  w_state_nxt = c_S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      w_busy = 1'b0;
      if (r_state == c_S_RUN) w_busy = 1'b1;
   end

   // Datapath: latch pending result, count down, commit to HI/LO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_res_hi  <= 32'd0;
         r_res_lo  <= 32'd0;
         r_res_vld <= 1'b0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
      end else if (r_state == c_S_IDLE) begin
         if (bus.start) begin
            case (bus.mdop)
               c_OP_MULT: begin
                  r_res_hi  <= w_prod_s[63:32];
                  r_res_lo  <= w_prod_s[31:0];
                  r_res_vld <= 1'b1;
                  r_cnt     <= c_MULT_CNT;
               end
               c_OP_MULTU: begin
                  r_res_hi  <= w_prod_u[63:32];
                  r_res_lo  <= w_prod_u[31:0];
                  r_res_vld <= 1'b1;
                  r_cnt     <= c_MULT_CNT;
               end
               c_OP_DIV, c_OP_DIVU: begin
                  r_res_hi  <= w_rem;
                  r_res_lo  <= w_quot;
                  // Divide by zero still burns the window but leaves HI/LO alone
                  r_res_vld <= !w_div_zero;
                  r_cnt     <= c_DIV_CNT;
               end
               c_OP_MTHI: r_hi <= bus.srcA;
               c_OP_MTLO: r_lo <= bus.srcA;
               default: ;
            endcase
         end
      end else begin
         if (r_cnt == c_CNT_ONE) begin
            if (r_res_vld) begin
               r_hi <= r_res_hi;
               r_lo <= r_res_lo;
            end
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
         end
      end
   end

   assign bus.busy = w_busy;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
   // Stall covers the start cycle and the whole busy window; forced low in reset
   assign bus.stall_md = reset & bus.use_md_D & (w_busy | (bus.start & w_is_long));

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Directed self-checking bench for md_unit.
// Revision    : 1.0  initial release
// ============================================================================
module tb_md_unit;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   md_unit_if bus ();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample point lands 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one long op, check busy/stall each cycle of the window and the result
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic use_d,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      bus.start    = 1'b1;
      bus.mdop     = op;
      bus.srcA     = a;
      bus.srcB     = b;
      bus.use_md_D = use_d;
      #1;
      check_val({tag, " stall@start"}, {31'd0, bus.stall_md}, {31'd0, use_d});
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < n; i++) begin
         check_val({tag, " busy"},  {31'd0, bus.busy},     32'd1);
         check_val({tag, " stall"}, {31'd0, bus.stall_md}, {31'd0, use_d});
         tick();
      end
      check_val({tag, " busy done"},  {31'd0, bus.busy},     32'd0);
      check_val({tag, " stall done"}, {31'd0, bus.stall_md}, 32'd0);
      check_val({tag, " hi"}, bus.hi, exp_hi);
      check_val({tag, " lo"}, bus.lo, exp_lo);
      bus.use_md_D = 1'b0;
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      reset        = 1'b0;
      bus.start    = 1'b1;
      bus.mdop     = 3'b000;
      bus.srcA     = 32'd0;
      bus.srcB     = 32'd0;
      bus.use_md_D = 1'b1;
      #12;
      // Reset state, stall held low even with a pending-looking request
      check_val("rst busy",  {31'd0, bus.busy},     32'd0);
      check_val("rst hi",    bus.hi,                32'd0);
      check_val("rst lo",    bus.lo,                32'd0);
      check_val("rst stall", {31'd0, bus.stall_md}, 32'd0);
      bus.start    = 1'b0;
      bus.use_md_D = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      run_op("mult",  3'b000, 32'd3,          32'hFFFF_FFFE, 5,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", 3'b001, 32'hFFFF_FFFF,  32'd2,         5,  1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("div",   3'b010, 32'hFFFF_FFF9,  32'd2,         10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divov", 3'b010, 32'h8000_0000,  32'hFFFF_FFFF, 10, 1'b0, 32'h0000_0000, 32'h8000_0000);

      // mthi/mtlo: single edge, no busy, no stall even with use_md_D
      bus.start = 1'b1; bus.mdop = 3'b100; bus.srcA = 32'h11; bus.use_md_D = 1'b1;
      #1;
      check_val("mthi stall", {31'd0, bus.stall_md}, 32'd0);
      tick();
      check_val("mthi hi",   bus.hi, 32'h11);
      check_val("mthi busy", {31'd0, bus.busy}, 32'd0);
      bus.mdop = 3'b101; bus.srcA = 32'h22;
      tick();
      check_val("mtlo lo", bus.lo, 32'h22);
      check_val("mtlo hi", bus.hi, 32'h11);
      // Reserved op ignored
      bus.mdop = 3'b111; bus.srcA = 32'h99;
      tick();
      check_val("rsvd busy", {31'd0, bus.busy}, 32'd0);
      check_val("rsvd lo",   bus.lo, 32'h22);
      bus.start = 1'b0; bus.use_md_D = 1'b0;

      run_op("divu0", 3'b011, 32'h1234, 32'd0, 10, 1'b1, 32'h11, 32'h22);

      // Reset mid-run clears everything immediately
      bus.start = 1'b1; bus.mdop = 3'b000; bus.srcA = 32'd5; bus.srcB = 32'd7;
      tick();
      bus.start = 1'b0;
      tick();
      check_val("mid busy", {31'd0, bus.busy}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check_val("arst busy", {31'd0, bus.busy}, 32'd0);
      check_val("arst hi",   bus.hi, 32'd0);
      check_val("arst lo",   bus.lo, 32'd0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check_val("arst discard lo", bus.lo, 32'd0);

      // Starts during RUN are ignored, including mthi
      bus.start = 1'b1; bus.mdop = 3'b000; bus.srcA = 32'd6; bus.srcB = 32'd7;
      tick();
      bus.mdop = 3'b010; bus.srcA = 32'd100; bus.srcB = 32'd3;
      tick();
      bus.mdop = 3'b100; bus.srcA = 32'hDEAD;
      tick();
      check_val("ign hi", bus.hi, 32'd0);
      bus.start = 1'b0;
      tick();
      tick();
      check_val("ign busy", {31'd0, bus.busy}, 32'd1);
      tick();
      check_val("ign busy done", {31'd0, bus.busy}, 32'd0);
      check_val("ign hi final",  bus.hi, 32'd0);
      check_val("ign lo final",  bus.lo, 32'd42);
      tick();
      check_val("ign no rerun", {31'd0, bus.busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
